// File: rtl/ram_bit_pack_writer_32.sv
`timescale 1ns/1ps
// Purpose : packs a serial valid/ready bit stream into DATA_WIDTH-bit RAM words with write mask and bit count.
// Latency : a closed word appears on out_data one cycle after its final bit (or the flush) is accepted.
// Backpressure: in_ready = !out_valid | out_ready; a held word keeps out_* stable and stalls input.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_bit/in_valid/in_last     serial bit stream; in_last closes the current word
//   in_ready                    bit (and flush) accepted this cycle
//   flush                       pulse: close the partial word (latched if in_ready=0)
//   out_data/out_mask/out_count packed word, written-bit mask, number of bits (1..DATA_WIDTH)
//   out_valid/out_ready         RAM-side handshake
//
// Build option: define RAM_BITPACK_MSB_FIRST_EN to fill words from the MSB downward
// (partial words left-aligned). Count, handshake and latency are unchanged.

module ram_bit_pack_writer_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_bit,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_mask,
    output logic [IDX_WIDTH:0]    out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [IDX_WIDTH:0]    CNT_LAST = (IDX_WIDTH+1)'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ONE_HOT0 = DATA_WIDTH'(1);

    // Output-slot state: FILL = slot empty, HOLD = word presented to the RAM.
    // Bits keep accumulating in both states whenever in_ready is high.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mask;
    logic [IDX_WIDTH:0]    cnt;
    logic                  flush_pend;

    logic                  accept;
    logic                  flush_req;
    logic                  close;
    logic [IDX_WIDTH-1:0]  pos;
    logic [DATA_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] acc_upd;
    logic [DATA_WIDTH-1:0] mask_upd;
    logic [IDX_WIDTH:0]    cnt_upd;

    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        accept    = 1'b0;
        flush_req = 1'b0;
        pos       = '0;
        sel       = '0;
        acc_upd   = acc;
        mask_upd  = mask;
        cnt_upd   = cnt;
        close     = 1'b0;
        state_nxt = state;

        // Registered state and out_ready only: never looks at in_valid.
        in_ready  = (state == FILL) | out_ready;
        accept    = in_valid & in_ready;
        // A flush seen while stalled is replayed on the first ready cycle.
        flush_req = (flush | flush_pend) & in_ready;

`ifdef RAM_BITPACK_MSB_FIRST_EN
        pos = IDX_WIDTH'(DATA_WIDTH - 1) - cnt[IDX_WIDTH-1:0];
`else
        pos = cnt[IDX_WIDTH-1:0];
`endif
        sel = ONE_HOT0 << pos;

        if (accept) begin
            acc_upd  = in_bit ? (acc | sel) : acc;
            mask_upd = mask | sel;
            cnt_upd  = cnt + 1'b1;
        end

        // cnt_upd != 0 covers both a flush on an existing partial word and
        // a flush coincident with the first bit; an empty word is never emitted.
        close = (accept & ((cnt == CNT_LAST) | in_last))
              | (flush_req & (cnt_upd != '0));

        case (state)
            FILL: if (close) state_nxt = HOLD;
            HOLD: if (!close && out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            mask       <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_data   <= '0;
            out_mask   <= '0;
            out_count  <= '0;
        end else begin
            if (close) begin
                // close only happens with in_ready=1, so the slot is free or draining now.
                out_data  <= acc_upd;
                out_mask  <= mask_upd;
                out_count <= cnt_upd;
                acc       <= '0;
                mask      <= '0;
                cnt       <= '0;
            end else begin
                acc  <= acc_upd;
                mask <= mask_upd;
                cnt  <= cnt_upd;
            end

            if (in_ready) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule
